// File: rtl/cache_controller_2way_wb.sv
// Two-way set-associative data cache with two-word lines and LRU replacement.
// WRITE_BACK selects write-back/write-allocate or write-through/no-write-allocate.
module cache_controller_2way_wb #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10,
    parameter bit WRITE_BACK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_bus_in,
    input  logic [31:0] write_data_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    output logic [31:0] read_data_out,
    output logic        ready_out,
    input  logic [63:0] sram_read_data_in,
    input  logic        sram_ready_in,
    output logic [31:0] sram_addr_out,
    output logic [31:0] sram_write_data_out,
    output logic        sram_r_en_out,
    output logic        sram_w_en_out
);

    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB0   = 3'd1,
        ST_WB1   = 3'd2,
        ST_FILL  = 3'd3,
        ST_WT_WR = 3'd4
    } state_t;

    state_t                state_r;
    logic                  victim_r;
    logic [SETS-1:0]       valid_r [2];
    logic [SETS-1:0]       dirty_r [2];
    logic [SETS-1:0]       lru_r;
    logic [TAG_BITS-1:0]   tag_r   [2][SETS];
    logic [63:0]           data_r  [2][SETS];

    logic                  offset_s;
    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  load_s;
    logic                  store_s;
    logic                  req_s;
    logic                  hit0_s;
    logic                  hit1_s;
    logic                  hit_s;
    logic                  hit_way_s;
    logic                  victim_s;
    logic [63:0]           hit_line_s;
    logic [63:0]           victim_line_s;
    logic [TAG_BITS-1:0]   victim_tag_s;
    logic [63:0]           fill_line_s;

    function automatic logic [31:0] line_word(input logic [63:0] line, input logic off);
        return off ? line[63:32] : line[31:0];
    endfunction

    function automatic logic [63:0] word_merge(input logic [63:0] line, input logic off,
                                               input logic [31:0] word);
        return off ? {word, line[31:0]} : {line[63:32], word};
    endfunction

    function automatic logic [31:0] make_addr(input logic [TAG_BITS-1:0] t,
                                              input logic [INDEX_BITS-1:0] i, input logic o);
        logic [31:0] a;
        a = 32'd0;
        a[TAG_BITS+INDEX_BITS:INDEX_BITS+1] = t;
        a[INDEX_BITS:1] = i;
        a[0] = o;
        return a;
    endfunction

    assign offset_s      = address_bus_in[0];
    assign index_s       = address_bus_in[INDEX_BITS:1];
    assign tag_s         = address_bus_in[TAG_BITS+INDEX_BITS:INDEX_BITS+1];
    // A request with both enables high is a load.
    assign load_s        = mem_r_en_in;
    assign store_s       = mem_w_en_in & ~mem_r_en_in;
    assign req_s         = load_s | store_s;
    assign hit0_s        = valid_r[0][index_s] && (tag_r[0][index_s] == tag_s);
    assign hit1_s        = valid_r[1][index_s] && (tag_r[1][index_s] == tag_s);
    assign hit_s         = hit0_s | hit1_s;
    assign hit_way_s     = hit1_s;
    assign hit_line_s    = data_r[hit_way_s][index_s];
    assign victim_line_s = data_r[victim_r][index_s];
    assign victim_tag_s  = tag_r[victim_r][index_s];
    assign fill_line_s   = store_s ? word_merge(sram_read_data_in, offset_s, write_data_in)
                                   : sram_read_data_in;

    // Victim choice: empty left way, then empty right way, then the LRU way.
    always_comb begin
        if (!valid_r[0][index_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][index_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[index_s];
        end
    end

    // Pipeline handshake and SRAM request decode, driven from the state register.
    always_comb begin
        read_data_out       = 32'd0;
        ready_out           = 1'b0;
        sram_addr_out       = 32'd0;
        sram_write_data_out = 32'd0;
        sram_r_en_out       = 1'b0;
        sram_w_en_out       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                read_data_out = line_word(hit_line_s, offset_s);
                if (!req_s) begin
                    ready_out = 1'b1;
                end else if (hit_s) begin
                    // A write-through store hit still owes the SRAM its write.
                    ready_out = ~(store_s & ~WRITE_BACK);
                end else begin
                    ready_out = 1'b0;
                end
            end
            ST_WB0: begin
                sram_w_en_out       = 1'b1;
                sram_addr_out       = make_addr(victim_tag_s, index_s, 1'b0);
                sram_write_data_out = victim_line_s[31:0];
            end
            ST_WB1: begin
                sram_w_en_out       = 1'b1;
                sram_addr_out       = make_addr(victim_tag_s, index_s, 1'b1);
                sram_write_data_out = victim_line_s[63:32];
            end
            ST_FILL: begin
                sram_r_en_out = 1'b1;
                sram_addr_out = make_addr(tag_s, index_s, 1'b0);
                read_data_out = line_word(sram_read_data_in, offset_s);
                ready_out     = sram_ready_in;
            end
            ST_WT_WR: begin
                sram_w_en_out       = 1'b1;
                sram_addr_out       = address_bus_in;
                sram_write_data_out = write_data_in;
                ready_out           = sram_ready_in;
            end
            default: begin
                ready_out = 1'b0;
            end
        endcase
    end

    // Controller state, replacement bookkeeping and line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            victim_r   <= 1'b0;
            valid_r[0] <= {SETS{1'b0}};
            valid_r[1] <= {SETS{1'b0}};
            dirty_r[0] <= {SETS{1'b0}};
            dirty_r[1] <= {SETS{1'b0}};
            lru_r      <= {SETS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        if (hit_s) begin
                            lru_r[index_s] <= ~hit_way_s;
                            if (store_s) begin
                                data_r[hit_way_s][index_s] <=
                                    word_merge(hit_line_s, offset_s, write_data_in);
                                if (WRITE_BACK) begin
                                    dirty_r[hit_way_s][index_s] <= 1'b1;
                                end else begin
                                    state_r <= ST_WT_WR;
                                end
                            end
                        end else if (store_s && !WRITE_BACK) begin
                            state_r <= ST_WT_WR;
                        end else begin
                            victim_r <= victim_s;
                            if (valid_r[victim_s][index_s] && dirty_r[victim_s][index_s]) begin
                                state_r <= ST_WB0;
                            end else begin
                                state_r <= ST_FILL;
                            end
                        end
                    end
                end
                ST_WB0: begin
                    if (sram_ready_in) begin
                        state_r <= ST_WB1;
                    end
                end
                ST_WB1: begin
                    if (sram_ready_in) begin
                        state_r <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (sram_ready_in) begin
                        valid_r[victim_r][index_s] <= 1'b1;
                        dirty_r[victim_r][index_s] <= store_s;
                        tag_r[victim_r][index_s]   <= tag_s;
                        data_r[victim_r][index_s]  <= fill_line_s;
                        lru_r[index_s]             <= ~victim_r;
                        state_r                    <= ST_IDLE;
                    end
                end
                ST_WT_WR: begin
                    if (sram_ready_in) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
